// File: rtl/vec_arb_pkg.sv
// Shared types and helpers for the vector-unit arbiters.
package vec_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Index width that never collapses to zero bits (WIDTH==1 still needs a port).
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest request at or above ptr, else lowest overall.
module rr_pick
    import vec_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = clog2_min1(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [WIDTH-1:0] pick,
    output logic [IDX_W-1:0] pick_idx
);

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] sel;
    logic             found;

    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked = req & mask;
        // Nothing at/above the pointer: wrap around to plain static priority.
        sel = (|masked) ? masked : req;
    end

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel[i] && !found) begin
                pick[i]  = 1'b1;
                pick_idx = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until valid/ready handshake.
// Optional binary grant index output enabled by RR_ARB_GNT_IDX_EN.
module rr_arbiter
    import vec_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = clog2_min1(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] req_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] gnt_o,
    output logic             valid_o
`ifdef RR_ARB_GNT_IDX_EN
   ,output logic [IDX_W-1:0] gnt_idx_o
`endif
);

    arb_state_e       state;
    logic [WIDTH-1:0] gnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] ptr_q;
    logic             valid_q;

    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] pick_ptr;
    logic [WIDTH-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic             any_req;
    logic             handshake;

    assign any_req   = |req_i;
    assign handshake = (state == ARB_GRANT) && ready_i;

    always_comb begin
        ptr_nxt = (idx_q == IDX_W'(WIDTH - 1)) ? '0 : idx_q + IDX_W'(1);
        // Back-to-back re-grant must already see the rotated pointer.
        pick_ptr = (state == ARB_GRANT) ? ptr_nxt : ptr_q;
    end

    rr_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (req_i),
        .ptr      (pick_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ARB_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        gnt_q   <= pick;
                        idx_q   <= pick_idx;
                        valid_q <= 1'b1;
                        state   <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (handshake) begin
                        ptr_q <= ptr_nxt;
                        if (any_req) begin
                            gnt_q   <= pick;
                            idx_q   <= pick_idx;
                            valid_q <= 1'b1;
                        end else begin
                            gnt_q   <= '0;
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            state   <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                    state   <= ARB_IDLE;
                end
            endcase
        end
    end

    assign gnt_o   = gnt_q;
    assign valid_o = valid_q;
`ifdef RR_ARB_GNT_IDX_EN
    assign gnt_idx_o = idx_q;
`endif

endmodule
